// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
package nibble_serial_add_ctrl_pkg;
    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/nibble_serial_add_ctrl_four_bit_adder.sv
// Shared 4-bit ripple-carry adder; purely combinational.
module Four_Bit_Adder
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] out,
    output logic                cout
);
    logic c;

    always_comb begin
        c   = cin;
        out = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            out[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract sequenced through one 4-bit adder, LSB nibble first,
// carry held in a register between nibbles.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*NIBBLES-1:0]    op_a,
    input  logic [4*NIBBLES-1:0]    op_b,
    input  logic                    cin,
    input  logic                    sub,
    output logic                    busy,
    output logic                    done,
    output logic [4*NIBBLES-1:0]    sum,
    output logic                    cout,
    output logic                    ovf
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]          state_q, state_d;
    logic [W-1:0]        opa_q, opa_d;
    logic [W-1:0]        opb_q, opb_d;
    logic [W-1:0]        res_q, res_d;
    logic [W-1:0]        sum_q, sum_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                a_msb_q, a_msb_d;
    logic                b_msb_q, b_msb_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] add_out;
    logic                add_cout;
    logic [W-1:0]        opb_eff;
    logic [W-1:0]        res_next;
    logic                accept;

    Four_Bit_Adder u_adder (
        .a    (opa_q[NIBBLE_W-1:0]),
        .b    (opb_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .out  (add_out),
        .cout (add_cout)
    );

    // Subtraction is A + ~B + ~borrow, so inversion happens once at capture.
    assign opb_eff  = sub ? ~op_b : op_b;
    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign res_next = {add_out, res_q[W-1:NIBBLE_W]};

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (state_q == ST_RUN) begin
            opa_d   = opa_q >> NIBBLE_W;
            opb_d   = opb_q >> NIBBLE_W;
            res_d   = res_next;
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
                idx_d   = '0;
                sum_d   = res_next;
                cout_d  = add_cout;
                ovf_d   = (a_msb_q == b_msb_q) && (add_out[NIBBLE_W-1] != a_msb_q);
            end
        end else if (accept) begin
            state_d = ST_RUN;
            opa_d   = op_a;
            opb_d   = opb_eff;
            carry_d = sub ? ~cin : cin;
            idx_d   = '0;
            a_msb_d = op_a[W-1];
            b_msb_d = opb_eff[W-1];
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule
